// File: rtl/deltastress_pkg.sv
// Shared types for the stress trend detector: trend state encoding and its width.
package deltastress_pkg;

    localparam int TREND_W = 2;

    typedef enum logic [TREND_W-1:0] {
        TREND_INIT   = 2'd0,
        TREND_STEADY = 2'd1,
        TREND_UP     = 2'd2,
        TREND_DOWN   = 2'd3
    } trend_t;

endpackage

// File: rtl/delta_stress_trend_sat_counter.sv
// Saturating up-counter with synchronous clear, used to count consecutive equal comparisons.
module sat_counter #(
    parameter int MAX = 2,
    localparam int CW = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          at_max
);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CW'(MAX)) ? c : c + CW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

    assign at_max = (count == CW'(MAX));

endmodule

// File: rtl/delta_stress_trend.sv
// Stress-level trend detector: compares each strobed sample with a reference, pulses on rise/fall.
// Optional macro DELTA_STRESS_HYST_EN adds a HYST dead band and event-only reference updates.
module delta_stress_trend
    import deltastress_pkg::*;
#(
    parameter int WIDTH          = 3,
    parameter int STABLE_SAMPLES = 2,
    parameter int HYST           = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_en,
    input  logic [WIDTH-1:0]        status,
    output logic                    gestegen,
    output logic                    gedaald,
    output logic                    gelijk,
    output logic [TREND_W-1:0]      trend,
    output logic signed [WIDTH:0]   delta,
    output logic                    valid
);

`ifdef DELTA_STRESS_HYST_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif
    localparam int THRESH = HYST_EN ? HYST : 1;
    localparam logic signed [WIDTH:0] THR_S = (WIDTH + 1)'(THRESH);
    localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);

    trend_t              state_p1;
    logic [WIDTH-1:0]    ref_p1;
    logic signed [WIDTH:0] diff_p0;
    logic                rise_p0, fall_p0, cmp_p0, reach_p0, upd_p0;
    logic [CNT_W-1:0]    cnt_count;
    logic                cnt_at_max;

    // Stage p0: zero-extended subtraction cannot overflow in WIDTH+1 signed bits.
    assign diff_p0  = $signed({1'b0, status}) - $signed({1'b0, ref_p1});
    assign rise_p0  = (diff_p0 >= THR_S);
    assign fall_p0  = (diff_p0 <= -THR_S);
    assign cmp_p0   = sample_en & valid;
    assign reach_p0 = cnt_at_max | (cnt_count == CNT_W'(STABLE_SAMPLES - 1));
    // With the dead band, sub-threshold drift must accumulate against an unchanged reference.
    assign upd_p0   = ~HYST_EN | rise_p0 | fall_p0;

    sat_counter #(.MAX(STABLE_SAMPLES)) u_stable (
        .clk    (clk),
        .reset  (reset),
        .inc    (cmp_p0 & ~rise_p0 & ~fall_p0),
        .clr    (cmp_p0 & (rise_p0 | fall_p0)),
        .count  (cnt_count),
        .at_max (cnt_at_max)
    );

    // Stage p1: registered outputs and trend state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p1 <= TREND_INIT;
            ref_p1   <= '0;
            valid    <= 1'b0;
            gestegen <= 1'b0;
            gedaald  <= 1'b0;
            gelijk   <= 1'b0;
            delta    <= '0;
        end else begin
            gestegen <= 1'b0;
            gedaald  <= 1'b0;
            if (sample_en) begin
                if (!valid) begin
                    ref_p1   <= status;
                    valid    <= 1'b1;
                    state_p1 <= TREND_STEADY;
                    delta    <= '0;
                end else begin
                    delta <= diff_p0;
                    if (upd_p0) ref_p1 <= status;
                    if (rise_p0) begin
                        gestegen <= 1'b1;
                        gelijk   <= 1'b0;
                        state_p1 <= TREND_UP;
                    end else if (fall_p0) begin
                        gedaald  <= 1'b1;
                        gelijk   <= 1'b0;
                        state_p1 <= TREND_DOWN;
                    end else if (reach_p0) begin
                        gelijk   <= 1'b1;
                        state_p1 <= TREND_STEADY;
                    end
                end
            end
        end
    end

    assign trend = state_p1;

endmodule

// File: tb/tb_delta_stress_trend.sv
// Self-checking bench for delta_stress_trend: directed scenarios plus randomized samples vs a model.
module tb_delta_stress_trend;

    localparam int WIDTH  = 3;
    localparam int STABLE = 2;
    localparam int HYST   = 2;
`ifdef DELTA_STRESS_HYST_EN
    localparam int THR = HYST;
    localparam bit HYST_ON = 1'b1;
`else
    localparam int THR = 1;
    localparam bit HYST_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  sample_en = 1'b0;
    logic [WIDTH-1:0]      status = '0;
    logic                  gestegen, gedaald, gelijk, valid;
    logic [1:0]            trend;
    logic signed [WIDTH:0] delta;

    int checks = 0;
    int errors = 0;

    delta_stress_trend #(.WIDTH(WIDTH), .STABLE_SAMPLES(STABLE), .HYST(HYST)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .status    (status),
        .gestegen  (gestegen),
        .gedaald   (gedaald),
        .gelijk    (gelijk),
        .trend     (trend),
        .delta     (delta),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    // Behavioural reference: reference value, count of equal comparisons since the last event.
    int m_ref, m_run, e_tr, e_delta;
    bit m_have, e_up, e_dn;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ref <= 0; m_run <= 0; m_have <= 0;
            e_tr <= 0; e_delta <= 0; e_up <= 0; e_dn <= 0;
        end else begin : mdl
            int d;
            d = int'(status) - m_ref;
            e_up <= 0;
            e_dn <= 0;
            if (sample_en) begin
                if (!m_have) begin
                    m_have <= 1; m_ref <= int'(status); e_tr <= 1; e_delta <= 0;
                end else begin
                    e_delta <= d;
                    if (d >= THR) begin
                        e_up <= 1; e_tr <= 2; m_run <= 0; m_ref <= int'(status);
                    end else if (d <= -THR) begin
                        e_dn <= 1; e_tr <= 3; m_run <= 0; m_ref <= int'(status);
                    end else begin
                        m_run <= m_run + 1;
                        if (m_run + 1 >= STABLE) e_tr <= 1;
                        if (!HYST_ON) m_ref <= int'(status);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (gestegen !== e_up || gedaald !== e_dn || gelijk !== (m_run >= STABLE) ||
            int'(trend) != e_tr || int'(delta) != e_delta || valid !== m_have) begin
            errors++;
            $display("FAIL model t=%0t: got up=%0b dn=%0b eq=%0b tr=%0d d=%0d v=%0b, need up=%0b dn=%0b eq=%0b tr=%0d d=%0d v=%0b",
                     $time, gestegen, gedaald, gelijk, trend, delta, valid,
                     e_up, e_dn, (m_run >= STABLE), e_tr, e_delta, m_have);
        end
    end

    task automatic expect_out(input string name, input bit up, input bit dn, input bit eq,
                              input int tr, input int d, input bit v);
        checks++;
        if (gestegen !== up || gedaald !== dn || gelijk !== eq || int'(trend) != tr ||
            int'(delta) != d || valid !== v) begin
            errors++;
            $display("FAIL %s: got up=%0b dn=%0b eq=%0b tr=%0d d=%0d v=%0b, need up=%0b dn=%0b eq=%0b tr=%0d d=%0d v=%0b",
                     name, gestegen, gedaald, gelijk, trend, delta, valid, up, dn, eq, tr, d, v);
        end
    endtask

    task automatic sample(input int v);
        @(negedge clk);
        sample_en = 1'b1;
        status = WIDTH'(v);
        @(negedge clk);
        sample_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int prev;

    initial begin
        repeat (2) @(negedge clk);
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        sample(3);  expect_out("first", 0, 0, 0, 1, 0, 1);
        sample(5);  expect_out("rise35", 1, 0, 0, 2, 2, 1);
        @(negedge clk); expect_out("pulse_end", 0, 0, 0, 2, 2, 1);
        sample(2);  expect_out("fall52", 0, 1, 0, 3, -3, 1);

        sample(4);  expect_out("rise24", 1, 0, 0, 2, 2, 1);
        sample(4);  expect_out("eq1", 0, 0, 0, 2, 0, 1);
        sample(4);  expect_out("eq2", 0, 0, 1, 1, 0, 1);
        sample(6);  expect_out("rise46", 1, 0, 0, 2, 2, 1);

        sample(0);  expect_out("fall60", 0, 1, 0, 3, -6, 1);
        sample(7);  expect_out("full_up", 1, 0, 0, 2, 7, 1);
        sample(0);  expect_out("full_dn", 0, 1, 0, 3, -7, 1);

        do_reset();
        sample(4);  expect_out("h_first", 0, 0, 0, 1, 0, 1);
`ifdef DELTA_STRESS_HYST_EN
        sample(5);  expect_out("h_small", 0, 0, 0, 1, 1, 1);
        sample(6);  expect_out("h_cross", 1, 0, 0, 2, 2, 1);
        sample(6);  expect_out("h_newref", 0, 0, 0, 2, 0, 1);
`else
        sample(5);  expect_out("n_small", 1, 0, 0, 2, 1, 1);
        sample(6);  expect_out("n_step", 1, 0, 0, 2, 1, 1);
        sample(6);  expect_out("n_eq", 0, 0, 0, 2, 0, 1);
`endif

        // Reset asserted between clock edges must clear outputs without waiting for a clock.
        sample(5);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 expect_out("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        sample(6);  expect_out("after_rst", 0, 0, 0, 1, 0, 1);

        // Back-to-back samples with sample_en held high.
        @(negedge clk); sample_en = 1'b1; status = 3'd1;
        @(negedge clk); status = 3'd2;
        @(negedge clk); expect_out("b2b_rise", 1, 0, 0, 2, 1, 1);
        status = 3'd1;
        @(negedge clk); expect_out("b2b_fall", 0, 1, 0, 3, -1, 1);
        sample_en = 1'b0;

        prev = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                sample_en = 1'b0;
            end else begin
                reset = 1'b0;
                sample_en = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 9) < 4) status = WIDTH'(prev);
                else if ($urandom_range(0, 9) < 3) status = ($urandom_range(0, 1) == 1) ? '1 : '0;
                else status = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
                prev = int'(status);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        sample_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
